// File: rtl/p05_arb_pkg.sv
// p05_arb_pkg: shared FSM state type and default sizing constants for the round-robin arbiter.
package p05_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   localparam int N_REQ_DEFAULT = 4;
   localparam int MAX_HOLD_DEFAULT = 15;
endpackage

// File: rtl/p05_rr_pick.sv
// p05_rr_pick: combinational search for the first set request at or above ptr, wrapping to 0.
module p05_rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);
   logic [W:0]   s;
   logic [W-1:0] j;
   // Scan farthest-first so the candidate nearest ptr is the last one written.
   always_comb begin
      found = |req;
      idx = '0;
      s = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         s = {1'b0, ptr} + (W+1)'(k);
         j = (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : W'(s);
         if (req[j]) idx = j;
      end
   end
endmodule

// File: rtl/p05_rr_arbiter.sv
// p05_rr_arbiter: round-robin arbiter with held grants and a dead cycle between grants.
// Define P05_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module p05_rr_arbiter
   import p05_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   output logic [N_REQ-1:0]           gnt,
   output logic                       gnt_valid,
   output logic [$clog2(N_REQ)-1:0]   gnt_id,
   output logic                       timeout
);
   localparam int W = $clog2(N_REQ);
   state_t           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [W-1:0]     gnt_id_q;
   logic [W-1:0]     ptr_q;
   logic             gnt_valid_q;
   logic             pick_found;
   logic [W-1:0]     pick_idx;
`ifdef P05_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q;
   logic       timeout_q;
`endif
   p05_rr_pick #(.N(N_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         gnt_q <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q <= '0;
`ifdef P05_ARB_TIMEOUT_EN
         hold_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef P05_ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         if (state_q == GRANT) begin
            if (!req[gnt_id_q]) begin
               state_q <= RELEASE;
               gnt_q <= '0;
               gnt_valid_q <= 1'b0;
               gnt_id_q <= '0;
`ifdef P05_ARB_TIMEOUT_EN
            end else if (hold_q == HOLD_LAST) begin
               state_q <= RELEASE;
               gnt_q <= '0;
               gnt_valid_q <= 1'b0;
               gnt_id_q <= '0;
               timeout_q <= 1'b1;
            end else begin
               hold_q <= hold_q + 8'd1;
`endif
            end
         end else if (pick_found) begin
            state_q <= GRANT;
            gnt_q <= N_REQ'(1) << pick_idx;
            gnt_valid_q <= 1'b1;
            gnt_id_q <= pick_idx;
            ptr_q <= (pick_idx == W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef P05_ARB_TIMEOUT_EN
            hold_q <= '0;
`endif
         end else begin
            state_q <= IDLE;
         end
      end
   end
   assign gnt = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id = gnt_id_q;
`ifdef P05_ARB_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_p05_rr_arbiter.sv
// tb_p05_rr_arbiter: directed checks of grant order, hold, release, reset and random invariants.
module tb_p05_rr_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       timeout;
   int         errors = 0;
   int         checks = 0;

   p05_rr_arbiter #(.N_REQ(4), .MAX_HOLD(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic expect_g(input string tag, input logic [3:0] g, input logic [1:0] id, input logic to = 1'b0);
      chk({tag, ".gnt"}, 32'(gnt), 32'(g));
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(g != 4'b0));
      chk({tag, ".id"}, 32'(gnt_id), 32'(id));
      chk({tag, ".timeout"}, 32'(timeout), 32'(to));
   endtask

   initial begin
      logic [3:0] req_prev;
      // Reset wins over a full request vector.
      req = 4'b1111;
      tick();
      tick();
      expect_g("reset", 4'b0000, 2'd0);
      rst = 1'b0;
      tick(); expect_g("seq_g0", 4'b0001, 2'd0);
      tick(); expect_g("seq_hold0", 4'b0001, 2'd0);
      req = 4'b1110; tick(); expect_g("seq_rel0", 4'b0000, 2'd0);
      req = 4'b1111; tick(); expect_g("seq_g1", 4'b0010, 2'd1);
      req = 4'b1101; tick(); expect_g("seq_rel1", 4'b0000, 2'd0);
      req = 4'b1111; tick(); expect_g("seq_g2", 4'b0100, 2'd2);
      req = 4'b1011; tick(); expect_g("seq_rel2", 4'b0000, 2'd0);
      req = 4'b1111; tick(); expect_g("seq_g3", 4'b1000, 2'd3);
      req = 4'b0111; tick(); expect_g("seq_rel3", 4'b0000, 2'd0);
      req = 4'b1111; tick(); expect_g("seq_wrap0", 4'b0001, 2'd0);
      req = 4'b0000; tick(); expect_g("seq_rel", 4'b0000, 2'd0);
      tick(); expect_g("seq_idle", 4'b0000, 2'd0);
      // Same index drops and re-requests: it passes through RELEASE and loses to 1.
      req = 4'b0001; tick(); expect_g("same_g0", 4'b0001, 2'd0);
      req = 4'b0011; tick(); expect_g("same_ignore1", 4'b0001, 2'd0);
      req = 4'b0010; tick(); expect_g("same_rel", 4'b0000, 2'd0);
      req = 4'b0011; tick(); expect_g("same_g1", 4'b0010, 2'd1);
      req = 4'b0000; tick(); tick(); expect_g("same_idle", 4'b0000, 2'd0);
      // Holder 1 (ptr=2), req[3] pulses and is forgotten.
      req = 4'b0010; tick(); expect_g("pulse_g1", 4'b0010, 2'd1);
      req = 4'b1010; tick(); expect_g("pulse_hold", 4'b0010, 2'd1);
      req = 4'b0010; tick(); expect_g("pulse_hold2", 4'b0010, 2'd1);
      req = 4'b0000; tick(); expect_g("pulse_rel", 4'b0000, 2'd0);
      tick(); expect_g("pulse_forgot", 4'b0000, 2'd0);
      // Holder 1 with req[3] rising mid-grant.
      req = 4'b0010; tick(); expect_g("mid_g1", 4'b0010, 2'd1);
      req = 4'b1010; tick(); expect_g("mid_hold", 4'b0010, 2'd1);
      tick(); expect_g("mid_hold2", 4'b0010, 2'd1);
      req = 4'b1000; tick(); expect_g("mid_dead", 4'b0000, 2'd0);
      tick(); expect_g("mid_g3", 4'b1000, 2'd3);
      req = 4'b0000; tick(); tick(); expect_g("mid_idle", 4'b0000, 2'd0);
      // Single requester 2.
      req = 4'b0100; tick(); expect_g("one_g2", 4'b0100, 2'd2);
      tick(); tick(); expect_g("one_hold", 4'b0100, 2'd2);
      req = 4'b0000; tick(); expect_g("one_rel", 4'b0000, 2'd0);
      tick(); expect_g("one_idle", 4'b0000, 2'd0);
      // Reset mid-grant clears ptr too: first grant afterwards is 0, not 3.
      req = 4'b0100; tick(); expect_g("rg_g2", 4'b0100, 2'd2);
      rst = 1'b1; tick(); expect_g("rg_rst", 4'b0000, 2'd0);
      rst = 1'b0; req = 4'b1111; tick(); expect_g("rg_first0", 4'b0001, 2'd0);
      req = 4'b0000; tick(); tick();
`ifdef P05_ARB_TIMEOUT_EN
      req = 4'b0001; tick(); expect_g("to_g0", 4'b0001, 2'd0);
      tick(); tick(); expect_g("to_hold", 4'b0001, 2'd0);
      tick(); expect_g("to_pulse", 4'b0000, 2'd0, 1'b1);
      tick(); expect_g("to_regrant", 4'b0001, 2'd0);
      req = 4'b0000; tick(); tick();
`endif
      // Random invariants: one-hot gnt, consistent id/valid, gnt only to a requester sampled high.
      req_prev = req;
      for (int c = 0; c < 400; c++) begin
         if (c % 3 == 0) req = 4'($urandom_range(0, 15));
         req_prev = req;
         tick();
         chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
         chk("rnd_req", 32'(gnt & ~req_prev), 32'd0);
         chk("rnd_valid", 32'(gnt_valid), 32'(gnt != 4'b0));
         chk("rnd_id", 32'(gnt_valid ? gnt : 4'b0), 32'(gnt_valid ? (4'b1 << gnt_id) : 4'b0));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/p05_rr_arbiter.md
P05_RR_ARBITER -- requirements
Module: p05_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 15, maximum grant length in cycles (1..255); used only with timeout compiled in.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  N_REQ  per-requester request, level, held for the whole use of the shared cell bank.
REQ-006 SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-007 SHALL have port gnt_valid  output  1  high when any gnt bit is high.
REQ-008 SHALL have port gnt_id  output  $clog2(N_REQ)  index of granted requester; 0 when gnt_valid low.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

Function
REQ-010 SHALL implement states IDLE, GRANT, RELEASE.
REQ-011 IDLE: if any req bit high at edge t, SHALL select the winner, set gnt and go to GRANT at edge t; outputs visible in cycle t+1.
REQ-012 Winner SHALL be the first set req bit searching upward from pointer ptr, wrapping N_REQ-1 to 0.
REQ-013 On each grant to index i, ptr SHALL become (i+1) mod N_REQ.
REQ-014 GRANT: gnt SHALL hold while req[gnt_id] stays high; other req changes SHALL be ignored.
REQ-015 GRANT: when req[gnt_id] is sampled low, gnt SHALL clear at that edge and the state SHALL go to RELEASE.
REQ-016 RELEASE SHALL last exactly one cycle with gnt all-zero, then arbitrate as IDLE does; this gives at least one dead cycle between successive grants.
REQ-017 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req was low at the grant edge.
REQ-018 A req pulse that drops before being granted SHALL be forgotten; there is no request latching.
REQ-019 Simultaneous release and new request from the same index SHALL still pass through RELEASE; that index then has the lowest priority.
REQ-020 With req all-zero in IDLE or RELEASE, state SHALL go to or stay in IDLE with outputs zero.

Reset
REQ-021 rst high at an edge SHALL force state IDLE, ptr 0, gnt 0, gnt_valid 0, gnt_id 0, timeout 0, and hold counter 0, in any state including mid-grant.
REQ-022 rst SHALL take priority over every other event at the same edge; the first arbitration is at the first edge with rst low.

Configuration
REQ-023 Macro P05_ARB_TIMEOUT_EN SHALL compile in the grant timeout.
REQ-024 With P05_ARB_TIMEOUT_EN: a hold counter SHALL clear on each grant and increment each GRANT cycle. When it reaches MAX_HOLD with req still high, gnt SHALL clear, timeout SHALL pulse for one cycle and the state SHALL go to RELEASE. ptr is already past the holder.
REQ-025 Without P05_ARB_TIMEOUT_EN: no counter logic SHALL exist, timeout SHALL be tied 0, and a grant SHALL last until release.

Structure
REQ-026 Shared package p05_arb_pkg SHALL hold the state enum (IDLE, GRANT, RELEASE) and the default constants N_REQ_DEFAULT=4 and MAX_HOLD_DEFAULT=15.
REQ-027 The rotating priority search SHALL be a combinational sub-module p05_rr_pick with inputs req and ptr and outputs found and idx.
REQ-028 All outputs SHALL come straight from flops, with no combinational path from req.

Verification
REQ-029 Reset then req=4'b1111 held: the grant sequence SHALL be 0,1,2,3,0. Each grant lasts while held; drop req[gnt_id] to release. One zero cycle between grants.
REQ-030 req=4'b0100 at cycle 5 -> gnt=4'b0100 and gnt_id=2 in cycle 6. req[2] low at cycle 9 -> gnt=0 in cycle 10, IDLE in cycle 11.
REQ-031 Holder 1 with req[3] rising mid-grant -> gnt stays 4'b0010 until req[1] drops, then gnt=4'b1000 after one dead cycle.
REQ-032 rst asserted during GRANT of index 2 -> gnt=0 next cycle. After rst low with req=4'b1111, the first grant SHALL be index 0.
REQ-033 With P05_ARB_TIMEOUT_EN, MAX_HOLD=3 and req=4'b0001 held: gnt high 3 cycles, then timeout=1 with gnt=0. Index 0 is regranted after the RELEASE cycle.
REQ-034 Random req stimulus, 10k cycles: assert one-hot gnt, no grant without req, and no requester waiting more than N_REQ grants while holding req high.
